// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: datapath width, operation encoding
// and the registered output bundle.
package alu_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned SEL_W  = 3;

    // Operation select encoding; all eight codes are defined.
    typedef enum logic [SEL_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    // Result plus status flags, as held in the output register.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             carry;
        logic             overf;
    } alu_out_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational 8-bit adder/subtractor. Subtraction is a + ~b + 1.
// Ports:
//   a, b   - operands
//   sub    - 1 selects subtraction
//   sum    - 8-bit wrapped result
//   cout   - raw carry-out (for subtraction, borrow = ~cout)
//   ovf    - signed two's-complement overflow
module alu_addsub
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;

    // Invert b and inject the +1 through the carry-in for subtraction.
    always_comb begin
        b_eff   = sub ? ~b : b;
        sum_ext = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
        sum     = sum_ext[WIDTH-1:0];
        cout    = sum_ext[WIDTH];
        // Same-sign effective operands producing a different-sign sum.
        ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU with zero/carry/overflow flags and one cycle latency.
// Ports:
//   clk    - clock, all updates on rising edge
//   reset  - synchronous active-high, clears all outputs
//   inA    - operand A
//   inB    - operand B
//   sel    - operation select (see alu_pkg::op_e)
//   result - registered result
//   zero   - registered, result == 0 for computed results
//   carry  - registered carry / borrow / shift-out
//   overF  - registered signed overflow
module alu_8bit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overF
);

    op_e              op;
    logic [WIDTH-1:0] as_sum;
    logic             as_cout;
    logic             as_ovf;
    alu_out_t         nxt;
    alu_out_t         q;

    assign op = op_e'(sel);

    alu_addsub u_addsub (
        .a    (inA),
        .b    (inB),
        .sub  (op == OP_SUB),
        .sum  (as_sum),
        .cout (as_cout),
        .ovf  (as_ovf)
    );

    // Operation mux and flag generation.
    always_comb begin
        nxt = '0;
        unique case (op)
            OP_ADD: begin
                nxt.result = as_sum;
                nxt.carry  = as_cout;
                nxt.overf  = as_ovf;
            end
            OP_SUB: begin
                nxt.result = as_sum;
                nxt.carry  = ~as_cout;
                nxt.overf  = as_ovf;
            end
            OP_AND: nxt.result = inA & inB;
            OP_OR:  nxt.result = inA | inB;
            OP_XOR: nxt.result = inA ^ inB;
            OP_NOT: nxt.result = ~inA;
            OP_SHL: begin
                nxt.result = {inA[WIDTH-2:0], 1'b0};
                nxt.carry  = inA[WIDTH-1];
            end
            OP_SHR: begin
                nxt.result = {1'b0, inA[WIDTH-1:1]};
                nxt.carry  = inA[0];
            end
            default: ;
        endcase
        nxt.zero = (nxt.result == '0);
    end

    // Output register; reset forces all-zero including the zero flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

    assign result = q.result;
    assign zero   = q.zero;
    assign carry  = q.carry;
    assign overF  = q.overf;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed self-checking bench for alu_8bit.
module tb_alu_8bit;

    logic       clk;
    logic       reset;
    logic [7:0] inA;
    logic [7:0] inB;
    logic [2:0] sel;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       overF;

    int checks   = 0;
    int failures = 0;

    alu_8bit dut (
        .clk    (clk),
        .reset  (reset),
        .inA    (inA),
        .inB    (inB),
        .sel    (sel),
        .result (result),
        .zero   (zero),
        .carry  (carry),
        .overF  (overF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] r, input logic z,
                             input logic c, input logic o);
        check({tag, ".result"}, result, r);
        check({tag, ".zero"},   8'(zero),  8'(z));
        check({tag, ".carry"},  8'(carry), 8'(c));
        check({tag, ".overF"},  8'(overF), 8'(o));
    endtask

    // Apply inputs away from the edge, then sample just after the next rising edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        @(negedge clk);
        inA = a;
        inB = b;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        inA   = 8'h33;
        inB   = 8'hA7;
        sel   = 3'd1;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Release reset; first computed result after the next edge
        @(negedge clk);
        reset = 1'b0;
        check_all("pre_first_edge", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("sub_33_a7", 8'h8C, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_all("sub_held", 8'h8C, 1'b0, 1'b1, 1'b1);

        // ADD cases
        step(8'h33, 8'hA7, 3'd0);
        check_all("add_33_a7", 8'hDA, 1'b0, 1'b0, 1'b0);
        step(8'hFF, 8'h01, 3'd0);
        check_all("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0);
        step(8'h7F, 8'h01, 3'd0);
        check_all("add_7f_01", 8'h80, 1'b0, 1'b0, 1'b1);
        step(8'h05, 8'h05, 3'd1);
        check_all("sub_equal", 8'h00, 1'b1, 1'b0, 1'b0);

        // Logic ops
        step(8'h33, 8'hA7, 3'd2);
        check_all("and", 8'h23, 1'b0, 1'b0, 1'b0);
        step(8'h33, 8'hA7, 3'd3);
        check_all("or", 8'hB7, 1'b0, 1'b0, 1'b0);
        step(8'h33, 8'hA7, 3'd4);
        check_all("xor", 8'h94, 1'b0, 1'b0, 1'b0);
        step(8'h33, 8'hA7, 3'd5);
        check_all("not", 8'hCC, 1'b0, 1'b0, 1'b0);
        step(8'hFF, 8'h12, 3'd5);
        check_all("not_ff", 8'h00, 1'b1, 1'b0, 1'b0);

        // Shifts
        step(8'h81, 8'h00, 3'd6);
        check_all("shl_81", 8'h02, 1'b0, 1'b1, 1'b0);
        step(8'h81, 8'h00, 3'd7);
        check_all("shr_81", 8'h40, 1'b0, 1'b1, 1'b0);
        step(8'h01, 8'h00, 3'd7);
        check_all("shr_01", 8'h00, 1'b1, 1'b1, 1'b0);
        step(8'h40, 8'h00, 3'd6);
        check_all("shl_40", 8'h80, 1'b0, 1'b0, 1'b0);

        // Latency: inputs change between edges with no visible effect until the edge
        step(8'h33, 8'hA7, 3'd0);
        check_all("lat_add", 8'hDA, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        sel = 3'd2;
        #1;
        check_all("lat_no_comb", 8'hDA, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("lat_and", 8'h23, 1'b0, 1'b0, 1'b0);
        step(8'h33, 8'hA7, 3'd3);
        check_all("lat_or", 8'hB7, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream for one edge
        @(negedge clk);
        reset = 1'b1;
        sel   = 3'd4;
        @(posedge clk);
        #1;
        check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all("resume_xor", 8'h94, 1'b0, 1'b0, 1'b0);
        step(8'h33, 8'hA7, 3'd1);
        check_all("resume_sub", 8'h8C, 1'b0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_8bit.md
# alu_8bit

Registered 8-bit arithmetic/logic unit with a 3-bit operation select and zero/carry/overflow status flags. Both operands and the select are sampled on each rising clock edge. Result and flags are registered, so they appear one cycle later. The block is a datapath leaf that a controller or register file feeds each cycle; it has no handshake.

## Interface
Parameters: none. Width is fixed at 8 bits.

Synchronization: one clock; reset is synchronous and active-high.

- clk — input, 1 — single clock; all state updates on the rising edge.
- reset — input, 1 — synchronous, active-high; clears all outputs.
- inA — input, 8 — operand A.
- inB — input, 8 — operand B.
- sel — input, 3 — operation select.
- result — output, 8 — registered operation result.
- zero — output, 1 — registered; 1 when the result is 0x00.
- carry — output, 1 — registered carry/borrow/shift-out flag.
- overF — output, 1 — registered signed (two's-complement) overflow flag.

## Operation
Op encoding (sel):
- 0 ADD: A+B. carry = bit 8 of the 9-bit sum. overF = 1 when operands have the same sign and the result sign differs.
- 1 SUB: A−B. carry = borrow, i.e. 1 when A < B unsigned. overF = 1 when operands differ in sign and the result sign differs from A.
- 2 AND: A&B. carry=0, overF=0.
- 3 OR: A|B. carry=0, overF=0.
- 4 XOR: A^B. carry=0, overF=0.
- 5 NOT: ~A. B is ignored. carry=0, overF=0.
- 6 SHL: A<<1, LSB filled with 0. carry = A[7]. overF=0.
- 7 SHR: A>>1 (logical), MSB filled with 0. carry = A[0]. overF=0.

General rules:
- zero is computed from the new 8-bit result for every op, including when carry=1 (for example, 0xFF+0x01 gives result 0x00, zero=1, carry=1).
- Arithmetic wraps modulo 256. No saturation.
- There are no illegal sel codes; all 8 are defined.

## Timing
- Latency is 1 cycle. Inputs present at rising edge N produce result and flags that are valid after edge N and held until edge N+1.
- Outputs change only on the rising edge. There is no combinational path from any input to any output.
- Reset value of every output is 0: result=0x00, zero=0, carry=0, overF=0.
- zero is 0 while in reset even though result is 0. zero is only evaluated for computed results.
- Reset has priority. If reset is high at an edge, the inputs are ignored for that edge.
- Reset deasserted at edge N: the first computed result appears after edge N+1, i.e. the first edge that samples reset=0.
- Reset asserted mid-stream clears outputs at the next edge. No in-flight operation survives.
- Inputs that change between edges have no effect until the next edge samples them.

## Structure
- Shared package alu_pkg:
  - op enum (OP_ADD=0 … OP_SHR=7), 3 bits wide.
  - WIDTH=8 constant.
- Sub-module alu_addsub:
  - Combinational 8-bit adder/subtractor.
  - Subtraction is A + ~B + 1.
  - Outputs the 8-bit sum, the raw carry-out (borrow = ~cout for SUB) and signed overflow.
- Top level contains:
  - the logic, NOT and shift muxing;
  - the zero detect;
  - the output register with synchronous reset.

## Test plan
- Reset: hold reset=1 for 2 edges with A=0x33, B=0xA7, sel=1 -> result=0x00, zero=0, carry=0, overF=0.
- SUB: after reset drops, A=0x33, B=0xA7, sel=1 -> one edge later result=0x8C, zero=0, carry=1, overF=1. Values stay stable while inputs are held.
- ADD:
  - A=0x33, B=0xA7, sel=0 -> result=0xDA, carry=0, overF=0.
  - A=0xFF, B=0x01 -> result=0x00, zero=1, carry=1, overF=0.
  - A=0x7F, B=0x01 -> result=0x80, overF=1, carry=0.
- Logic, A=0x33, B=0xA7:
  - sel=2 -> 0x23.
  - sel=3 -> 0xB7.
  - sel=4 -> 0x94.
  - sel=5 -> 0xCC.
  - Each has carry=0, overF=0.
- Shifts:
  - A=0x81, sel=6 -> result=0x02, carry=1.
  - A=0x81, sel=7 -> result=0x40, carry=1.
  - A=0x01, sel=7 -> result=0x00, zero=1, carry=1.
- Latency and reset mid-stream:
  - Change sel every cycle -> each result lags its inputs by exactly one edge.
  - Assert reset for one edge mid-sequence -> all outputs 0 at that edge, and normal results resume one edge after release.
